// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: decode/execute pipeline register with a valid/ready
// handshake backed by a 2-entry skid buffer, synchronous flush and a
// saturating stall counter.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   i_valid / o_ready   upstream handshake (o_ready is registered)
//   i_ctrl, i_dr1,
//   i_dr2, i_wa         incoming control word, operands, write address
//   i_flush             squash held and incoming transfers
//   o_valid / i_ready   downstream handshake
//   o_ctrl, o_dr1,
//   o_dr2, o_wa         held control word, operands, write address
//   o_stall_cnt         cycles with o_valid=1 and i_ready=0, saturating
module pipe_stage_buf #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CTRL_W      = 8,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_dr1,
  input  logic [DATA_W-1:0] i_dr2,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_dr1,
  output logic [DATA_W-1:0] o_dr2,
  output logic [ADDR_W-1:0] o_wa,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ready_q;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_dr1, skid_dr1;
  logic [DATA_W-1:0] main_dr2, skid_dr2;
  logic [ADDR_W-1:0] main_wa, skid_wa;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic xfer_in, xfer_out;
  logic load_main_in, load_main_skid, load_skid_in;

  assign o_valid  = (state_q != S_EMPTY);
  assign o_ready  = ready_q;
  assign xfer_in  = i_valid & ready_q;
  assign xfer_out = o_valid & i_ready;

  // Next state and storage load enables; flush overrides every transition
  // and discards the incoming word.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (i_flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (xfer_in) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (xfer_in && xfer_out) begin
            load_main_in = 1'b1;
          end else if (xfer_in) begin
            state_d      = S_TWO;
            load_skid_in = 1'b1;
          end else if (xfer_out) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer_out) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // o_ready is computed from the next state so it changes on the same edge
  // as the state, with no combinational path from i_valid/i_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != S_TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_ctrl <= '0;
      main_dr1  <= '0;
      main_dr2  <= '0;
      main_wa   <= '0;
      skid_ctrl <= '0;
      skid_dr1  <= '0;
      skid_dr2  <= '0;
      skid_wa   <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= i_ctrl;
        main_dr1  <= i_dr1;
        main_dr2  <= i_dr2;
        main_wa   <= i_wa;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_dr1  <= skid_dr1;
        main_dr2  <= skid_dr2;
        main_wa   <= skid_wa;
      end
      if (load_skid_in) begin
        skid_ctrl <= i_ctrl;
        skid_dr1  <= i_dr1;
        skid_dr2  <= i_dr2;
        skid_wa   <= i_wa;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (o_valid && !i_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Bubble masking keeps RAM/BR enables low whenever nothing is valid.
  always_comb begin
    o_ctrl = main_ctrl;
    if ((ZERO_BUBBLE != 0) && !o_valid) begin
      o_ctrl = '0;
    end
  end

  assign o_dr1       = main_dr1;
  assign o_dr2       = main_dr2;
  assign o_wa        = main_wa;
  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: three instances share one stimulus set --
// default parameters, ZERO_BUBBLE=0, and CNT_W=4 for saturation.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst, i_valid, i_flush, i_ready;
  logic [7:0]  i_ctrl;
  logic [31:0] i_dr1, i_dr2;
  logic [4:0]  i_wa;

  logic        o_ready, o_valid;
  logic [7:0]  o_ctrl;
  logic [31:0] o_dr1, o_dr2;
  logic [4:0]  o_wa;
  logic [15:0] o_stall_cnt;

  logic        nb_ready, nb_valid;
  logic [7:0]  nb_ctrl;
  logic [31:0] nb_dr1, nb_dr2;
  logic [4:0]  nb_wa;
  logic [15:0] nb_cnt;

  logic        c4_ready, c4_valid;
  logic [7:0]  c4_ctrl;
  logic [31:0] c4_dr1, c4_dr2;
  logic [4:0]  c4_wa;
  logic [3:0]  c4_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .ADDR_W(5), .ZERO_BUBBLE(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_ctrl(i_ctrl),
    .i_dr1(i_dr1), .i_dr2(i_dr2), .i_wa(i_wa), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_ctrl(o_ctrl), .o_dr1(o_dr1), .o_dr2(o_dr2), .o_wa(o_wa),
    .o_stall_cnt(o_stall_cnt));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .ADDR_W(5), .ZERO_BUBBLE(0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(nb_ready), .i_ctrl(i_ctrl),
    .i_dr1(i_dr1), .i_dr2(i_dr2), .i_wa(i_wa), .i_flush(i_flush), .o_valid(nb_valid),
    .i_ready(i_ready), .o_ctrl(nb_ctrl), .o_dr1(nb_dr1), .o_dr2(nb_dr2), .o_wa(nb_wa),
    .o_stall_cnt(nb_cnt));

  pipe_stage_buf #(.DATA_W(32), .CTRL_W(8), .ADDR_W(5), .ZERO_BUBBLE(1), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(c4_ready), .i_ctrl(i_ctrl),
    .i_dr1(i_dr1), .i_dr2(i_dr2), .i_wa(i_wa), .i_flush(i_flush), .o_valid(c4_valid),
    .i_ready(i_ready), .o_ctrl(c4_ctrl), .o_dr1(c4_dr1), .o_dr2(c4_dr2), .o_wa(c4_wa),
    .o_stall_cnt(c4_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] c, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] a);
    i_valid = 1'b1; i_ctrl = c; i_dr1 = d1; i_dr2 = d2; i_wa = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_ctrl = '0; i_dr1 = '0; i_dr2 = '0; i_wa = '0;
    tick();
    rst = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_ctrl !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", o_ctrl); end
    total++; if (nb_ctrl !== 8'h00) begin bad++; $display("FAIL reset_nb_ctrl got=%h exp=00", nb_ctrl); end
    total++; if (o_dr1 !== 32'h0) begin bad++; $display("FAIL reset_dr1 got=%h exp=0", o_dr1); end
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(8'h01 + 8'(i), vals[i], ~vals[i], 5'(i + 3));
      tick();
      total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, o_valid); end
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, o_ready); end
      total++; if (o_dr1 !== vals[i]) begin bad++; $display("FAIL stream_dr1[%0d] got=%h exp=%h", i, o_dr1, vals[i]); end
      total++; if (o_dr2 !== ~vals[i]) begin bad++; $display("FAIL stream_dr2[%0d] got=%h exp=%h", i, o_dr2, ~vals[i]); end
      total++; if (o_wa !== 5'(i + 3)) begin bad++; $display("FAIL stream_wa[%0d] got=%0d exp=%0d", i, o_wa, i + 3); end
      total++; if (o_ctrl !== 8'h01 + 8'(i)) begin bad++; $display("FAIL stream_ctrl[%0d] got=%h exp=%h", i, o_ctrl, 8'h01 + 8'(i)); end
    end
    i_valid = 1'b0;
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", o_valid); end
    total++; if (o_dr1 !== 32'h33333333) begin bad++; $display("FAIL stream_hold_dr1 got=%h exp=33333333", o_dr1); end
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL stream_cnt got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_back_pressure();
    i_ready = 1'b0;
    offer(8'h0A, 32'hA, 32'h0, 5'd1);
    tick();  // A accepted into main
    total++; if (o_dr1 !== 32'hA) begin bad++; $display("FAIL bp_a_dr1 got=%h exp=a", o_dr1); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_a_ready got=%b exp=1", o_ready); end
    offer(8'h0B, 32'hB, 32'h0, 5'd2);
    tick();  // B into skid
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_b_ready got=%b exp=0", o_ready); end
    total++; if (o_dr1 !== 32'hA) begin bad++; $display("FAIL bp_b_dr1 got=%h exp=a", o_dr1); end
    offer(8'h0C, 32'hC, 32'h0, 5'd3);
    tick();  // C refused
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_c_ready got=%b exp=0", o_ready); end
    total++; if (o_dr1 !== 32'hA) begin bad++; $display("FAIL bp_c_dr1 got=%h exp=a", o_dr1); end
    i_ready = 1'b1;
    tick();  // A out, B moves to main, C still refused
    total++; if (o_dr1 !== 32'hB) begin bad++; $display("FAIL bp_out_b got=%h exp=b", o_dr1); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_out_b_ready got=%b exp=1", o_ready); end
    tick();  // B out, C accepted
    total++; if (o_dr1 !== 32'hC) begin bad++; $display("FAIL bp_out_c got=%h exp=c", o_dr1); end
    total++; if (o_wa !== 5'd3) begin bad++; $display("FAIL bp_out_c_wa got=%0d exp=3", o_wa); end
    i_valid = 1'b0;
    tick();  // C out
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%b exp=0", o_valid); end
    total++; if (o_stall_cnt !== 16'd2) begin bad++; $display("FAIL bp_cnt got=%0d exp=2", o_stall_cnt); end
  endtask

  task automatic test_flush_two();
    i_ready = 1'b0;
    offer(8'hFF, 32'hE, 32'hE0, 5'd4);
    tick();
    offer(8'h5A, 32'hF, 32'hF0, 5'd5);
    tick();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_ready got=%b exp=0", o_ready); end
    offer(8'h77, 32'hD, 32'hD0, 5'd6);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", o_ready); end
    total++; if (o_ctrl !== 8'h00) begin bad++; $display("FAIL flush_ctrl got=%h exp=00", o_ctrl); end
    total++; if (nb_ctrl !== 8'hFF) begin bad++; $display("FAIL bubble_nb_ctrl got=%h exp=ff", nb_ctrl); end
    total++; if (o_dr1 !== 32'hE) begin bad++; $display("FAIL flush_hold_dr1 got=%h exp=e", o_dr1); end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_no_d[%0d] got=%b exp=0", i, o_valid); end
    end
    total++; if (o_stall_cnt !== 16'd4) begin bad++; $display("FAIL flush_cnt got=%0d exp=4", o_stall_cnt); end
  endtask

  task automatic test_saturation();
    i_ready = 1'b0;
    offer(8'h33, 32'h5, 32'h6, 5'd7);
    tick();
    i_valid = 1'b0;
    repeat (20) tick();
    total++; if (c4_cnt !== 4'd15) begin bad++; $display("FAIL sat_c4 got=%0d exp=15", c4_cnt); end
    total++; if (o_stall_cnt !== 16'd24) begin bad++; $display("FAIL sat_c16 got=%0d exp=24", o_stall_cnt); end
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (c4_cnt !== 4'd15) begin bad++; $display("FAIL sat_after_flush got=%0d exp=15", c4_cnt); end
    total++; if (c4_valid !== 1'b0) begin bad++; $display("FAIL sat_flush_valid got=%b exp=0", c4_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (c4_cnt !== 4'd0) begin bad++; $display("FAIL sat_after_rst got=%0d exp=0", c4_cnt); end
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL sat_c16_rst got=%0d exp=0", o_stall_cnt); end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0;
    offer(8'h81, 32'h1, 32'h10, 5'd8);
    tick();
    offer(8'h82, 32'h2, 32'h20, 5'd9);
    tick();
    total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL rmid_pre_ready got=%b exp=0", o_ready); end
    offer(8'h83, 32'h3, 32'h30, 5'd10);
    rst = 1'b1; i_flush = 1'b1;
    tick();
    rst = 1'b0; i_flush = 1'b0;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", o_valid); end
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", o_ready); end
    total++; if (nb_ctrl !== 8'h00) begin bad++; $display("FAIL rmid_ctrl got=%h exp=00", nb_ctrl); end
    total++; if (o_dr1 !== 32'h0) begin bad++; $display("FAIL rmid_dr1 got=%h exp=0", o_dr1); end
    total++; if (o_dr2 !== 32'h0) begin bad++; $display("FAIL rmid_dr2 got=%h exp=0", o_dr2); end
    total++; if (o_wa !== 5'd0) begin bad++; $display("FAIL rmid_wa got=%0d exp=0", o_wa); end
    total++; if (o_stall_cnt !== 16'd0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", o_stall_cnt); end
    i_ready = 1'b1;
    offer(8'h44, 32'h44, 32'h440, 5'd11);
    tick();
    total++; if (o_dr1 !== 32'h44) begin bad++; $display("FAIL rmid_next_dr1 got=%h exp=44", o_dr1); end
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_valid got=%b exp=1", o_valid); end
    i_valid = 1'b0;
    tick();
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_skid got=%b exp=0", o_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_two();
    test_saturation();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the single-cycle decode/execute pipeline register; carries control word, two register-file operands and write address between stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from the downstream stage never drops a transfer and never creates a combinational ready path upstream.
- Adds a synchronous flush for branch/hazard squash and a saturating stall counter for debug.

Parameters:
- DATA_W, 32, width of each operand (i_dr1/i_dr2).
- CTRL_W, 8, width of packed control word (RAM rd/wr enables, demux sel, ALU opcode, BR write enable).
- ADDR_W, 5, width of destination register address.
- ZERO_BUBBLE, 1, 1 = o_ctrl forced to 0 whenever o_valid=0; 0 = o_ctrl holds last value.
- CNT_W, 16, width of stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream has a transfer.
- o_ready  out  1  stage can accept (registered).
- i_ctrl  in  CTRL_W  control word.
- i_dr1  in  DATA_W  operand 1.
- i_dr2  in  DATA_W  operand 2.
- i_wa  in  ADDR_W  destination register address.
- i_flush  in  1  squash all held and incoming transfers.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_ctrl  out  CTRL_W  held control word.
- o_dr1  out  DATA_W  held operand 1.
- o_dr2  out  DATA_W  held operand 2.
- o_wa  out  ADDR_W  held destination address.
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0, saturating.

Behaviour:
- Transfer in: i_valid & o_ready at a rising edge. Transfer out: o_valid & i_ready at a rising edge.
- Storage: main entry (drives outputs) and skid entry. States:
  - EMPTY: main empty.
  - ONE: main full, skid empty.
  - TWO: both full.
- Transitions, with no flush:
  - EMPTY: in -> ONE (main loaded); otherwise stays EMPTY.
  - ONE: in & out -> ONE (main reloaded). In & !out -> TWO (skid loaded). Out & !in -> EMPTY. Otherwise stays ONE.
  - TWO: out -> ONE (skid moves to main). Otherwise stays TWO.
  - In TWO, o_ready=0, so no input is accepted.
- o_ready is registered: 1 in EMPTY and ONE, 0 in TWO. It updates on the same edge as the state change.
- Latency: an accepted transfer appears on the outputs 1 cycle later. Order is strictly preserved. Throughput is 1 per cycle while i_ready=1.
- o_valid=1 in ONE and TWO.
- ZERO_BUBBLE=1: o_ctrl=0 when o_valid=0, so a bubble never asserts RAM or BR enables. o_dr1, o_dr2 and o_wa hold their last value regardless.
- Flush (i_flush=1 at an edge):
  - Next state is EMPTY, o_valid=0 and o_ready=1.
  - The input offered that cycle is discarded, even if i_valid & o_ready.
  - An output transfer in the same cycle (o_valid & i_ready) still counts as delivered downstream.
  - Flush has priority over all other transitions.
- Stall counter:
  - Increments by 1 each edge with o_valid & !i_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst, not by flush.
- Reset (rst=1 at an edge):
  - State EMPTY, o_valid=0, o_ready=1.
  - o_ctrl, o_dr1, o_dr2 and o_wa are 0; skid contents are 0.
  - o_stall_cnt is 0.
  - Reset overrides flush and all handshakes.
  - Reset asserted mid-stream, including in TWO, drops both entries.
- No combinational path from i_ready or i_valid to o_ready. Outputs come only from registers (except the ZERO_BUBBLE mask, which depends only on the internal valid).

Test Plan:
- Reset then stream: rst 1 cycle; send i_dr1=0x11111111, 0x22222222 and 0x33333333 on consecutive cycles with i_ready=1 -> each appears on o_dr1 one cycle after acceptance, o_valid=1 for 3 cycles, o_ready stays 1.
- Back-pressure: hold i_ready=0 while sending A=0xA, then B=0xB, then C=0xC:
  - After B, o_ready=0 and C is not accepted.
  - Raise i_ready: outputs A, then B, then C, with no loss and no duplicate.
  - o_stall_cnt equals the number of stalled cycles.
- Flush in TWO: fill both entries, assert i_flush with i_valid=1 and D=0xD offered -> next cycle o_valid=0, o_ctrl=0, o_ready=1, and D never appears.
- Bubble masking: ZERO_BUBBLE=1; with o_valid=0 -> o_ctrl=0x00 even after a prior i_ctrl=0xFF. With ZERO_BUBBLE=0, o_ctrl holds 0xFF.
- Counter saturation: CNT_W=4; hold o_valid=1 and i_ready=0 for 20 cycles -> o_stall_cnt=15. Then assert i_flush -> count stays 15. Then assert rst -> count is 0.
- Reset mid-operation: in TWO, assert rst together with i_flush and i_valid -> next cycle all outputs 0, o_ready=1, and state EMPTY (next input is accepted and output 1 cycle later).
